// File: rtl/line_sched_pkg.sv
// Shared types and default sizing for the line-buffer ping-pong scheduler.
//   bank_state_t : life cycle of one line bank (FREE -> FILLING -> FULL -> READING)
//   rd_state_t   : reader handshake states (IDLE -> GRANT -> BUSY)
//   DEF_*        : default parameter values used by the interface and the top
package line_sched_pkg;

  localparam int DEF_ADDR_W      = 10;
  localparam int DEF_LINE_PIXELS = 320;
  localparam int DEF_LINE_CNT_W  = 9;

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2,
    READING = 2'd3
  } bank_state_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BUSY  = 2'd2
  } rd_state_t;

endpackage

// File: rtl/line_bank_scheduler_if.sv
// Signal bundle between the pixel source / LCD reader side and the scheduler.
//   slave  : scheduler view (frame sync, pixel strobe and reader handshake in;
//            RAM port-A write controls, grant/abort and status out)
//   master : environment view, directions mirrored
interface line_bank_scheduler_if
  import line_sched_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int LINE_CNT_W = DEF_LINE_CNT_W
);

  logic                  V_SYNC_I;
  logic                  WR_VALID_I;
  logic [ADDR_W-1:0]     WR_ADDR_I;
  logic                  WR_LINE_END_I;
  logic                  RD_REQ_I;
  logic                  RD_DONE_I;
  logic                  RAM_WE_O;
  logic [ADDR_W:0]       RAM_WR_ADDR_O;
  logic                  RD_GRANT_O;
  logic                  RD_BANK_O;
  logic                  RD_ABORT_O;
  logic [1:0]            LINES_FULL_O;
  logic                  OVERFLOW_O;
  logic [LINE_CNT_W-1:0] FRAME_LINE_O;

  modport slave (
    input  V_SYNC_I, WR_VALID_I, WR_ADDR_I, WR_LINE_END_I, RD_REQ_I, RD_DONE_I,
    output RAM_WE_O, RAM_WR_ADDR_O, RD_GRANT_O, RD_BANK_O, RD_ABORT_O,
           LINES_FULL_O, OVERFLOW_O, FRAME_LINE_O
  );

  modport master (
    output V_SYNC_I, WR_VALID_I, WR_ADDR_I, WR_LINE_END_I, RD_REQ_I, RD_DONE_I,
    input  RAM_WE_O, RAM_WR_ADDR_O, RD_GRANT_O, RD_BANK_O, RD_ABORT_O,
           LINES_FULL_O, OVERFLOW_O, FRAME_LINE_O
  );

endinterface

// File: rtl/line_bank_slot.sv
// State register for one line bank.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start_fill  : first accepted pixel of a line lands in this bank
//   close       : line end for the line being written into this bank
//   grant       : reader has been granted this bank
//   rd_release  : reader finished this bank
//   clear       : frame start, forces FREE
//   state       : current bank state
module line_bank_slot
  import line_sched_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_fill,
  input  logic        close,
  input  logic        grant,
  input  logic        rd_release,
  input  logic        clear,
  output bank_state_t state
);

  bank_state_t state_next;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_next = state;
    unique case (state)
      // A one-pixel line closes straight from FREE.
      FREE:    if (close) state_next = FULL;
               else if (start_fill) state_next = FILLING;
      FILLING: if (close) state_next = FULL;
      FULL:    if (grant) state_next = READING;
      READING: if (rd_release) state_next = FREE;
      default: state_next = FREE;
    endcase
    if (clear) state_next = FREE;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FREE;
    else        state <= state_next;
  end

endmodule

// File: rtl/line_bank_scheduler.sv
// Ping-pong scheduler for the two-line buffer RAM between the enhanced camera
// pixel stream and the LCD read FSM.
//   SYS_CLK_I, RESETN_I : clock, asynchronous active-low reset
//   bus (slave)         : V_SYNC_I frame start, WR_* pixel strobe, RD_REQ_I /
//                         RD_DONE_I reader handshake; RAM_WE_O / RAM_WR_ADDR_O
//                         registered port-A write, RD_GRANT_O / RD_BANK_O /
//                         RD_ABORT_O reader grant, LINES_FULL_O, OVERFLOW_O,
//                         FRAME_LINE_O status
// Lines are written alternately into bank 0 and bank 1 and handed to the
// reader in write order. When no bank is free at a line end, the next line is
// dropped and the switch is retried at every following line end.
module line_bank_scheduler
  import line_sched_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int LINE_PIXELS = DEF_LINE_PIXELS,
  parameter int LINE_CNT_W  = DEF_LINE_CNT_W
) (
  input logic                  SYS_CLK_I,
  input logic                  RESETN_I,
  line_bank_scheduler_if.slave bus
);

  localparam logic [ADDR_W:0] PIX_LIMIT = (ADDR_W + 1)'(LINE_PIXELS);

  logic                  vs_d;
  logic                  vs_rise;
  logic                  wr_bank;
  logic                  rd_ptr;
  logic                  drop;
  logic                  overflow;
  logic                  rd_bank;
  logic                  rd_abort;
  logic                  ram_we;
  logic [ADDR_W:0]       ram_wr_addr;
  logic [LINE_CNT_W-1:0] frame_line;
  logic [1:0]            lines_full;
  bank_state_t           bank_st [2];
  rd_state_t             rd_state;
  rd_state_t             rd_next;

  logic       pix;
  logic       line_end;
  logic       in_range;
  logic       done_fire;
  logic       other_free;
  logic [1:0] start_fill;
  logic [1:0] close;
  logic [1:0] grant;
  logic [1:0] rd_release;

  // Decode of this cycle's events. A frame-start edge swallows any pixel or
  // line end arriving with it.
  always_comb begin
    vs_rise    = bus.V_SYNC_I & ~vs_d;
    pix        = bus.WR_VALID_I & ~vs_rise;
    line_end   = pix & bus.WR_LINE_END_I;
    in_range   = {1'b0, bus.WR_ADDR_I} < PIX_LIMIT;
    done_fire  = (rd_state == BUSY) & bus.RD_DONE_I;
    // A bank released by the reader in this very cycle counts as free.
    other_free = (bank_st[~wr_bank] == FREE) | (done_fire & (rd_ptr == ~wr_bank));
    for (int b = 0; b < 2; b++) begin
      start_fill[b] = pix & ~drop & (wr_bank == 1'(b));
      close[b]      = line_end & ~drop & (wr_bank == 1'(b));
      grant[b]      = (rd_state == GRANT) & (rd_ptr == 1'(b));
      rd_release[b] = done_fire & (rd_ptr == 1'(b));
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_slot
    line_bank_slot u_slot (
      .clk        (SYS_CLK_I),
      .rst_n      (RESETN_I),
      .start_fill (start_fill[g]),
      .close      (close[g]),
      .grant      (grant[g]),
      .rd_release (rd_release[g]),
      .clear      (vs_rise),
      .state      (bank_st[g])
    );
  end

  // Reader FSM, next-state half.
  always_comb begin
    rd_next = rd_state;
    unique case (rd_state)
      IDLE:    if (bus.RD_REQ_I && (bank_st[rd_ptr] == FULL)) rd_next = GRANT;
      GRANT:   rd_next = BUSY;
      BUSY:    if (bus.RD_DONE_I) rd_next = IDLE;
      default: rd_next = IDLE;
    endcase
    if (vs_rise) rd_next = IDLE;
  end

  always_ff @(posedge SYS_CLK_I or negedge RESETN_I) begin
    if (!RESETN_I) begin
      rd_state <= IDLE;
      rd_ptr   <= 1'b0;
      rd_bank  <= 1'b0;
      rd_abort <= 1'b0;
    end else begin
      rd_state <= rd_next;
      rd_abort <= vs_rise & (rd_state != IDLE);
      if ((rd_state == IDLE) && (rd_next == GRANT)) rd_bank <= rd_ptr;
      if (vs_rise)        rd_ptr <= 1'b0;
      else if (done_fire) rd_ptr <= ~rd_ptr;
    end
  end

  // Registered RAM port-A write; the address holds between strobes.
  always_ff @(posedge SYS_CLK_I or negedge RESETN_I) begin
    if (!RESETN_I) begin
      vs_d        <= 1'b0;
      ram_we      <= 1'b0;
      ram_wr_addr <= '0;
    end else begin
      vs_d   <= bus.V_SYNC_I;
      ram_we <= pix & ~drop & in_range;
      if (pix) ram_wr_addr <= {wr_bank, bus.WR_ADDR_I};
    end
  end

  // Write-side bookkeeping: bank switch, drop handling, line counter.
  always_ff @(posedge SYS_CLK_I or negedge RESETN_I) begin
    if (!RESETN_I) begin
      wr_bank    <= 1'b0;
      drop       <= 1'b0;
      overflow   <= 1'b0;
      frame_line <= '0;
      lines_full <= 2'd0;
    end else if (vs_rise) begin
      wr_bank    <= 1'b0;
      drop       <= 1'b0;
      overflow   <= 1'b0;
      frame_line <= '0;
      lines_full <= 2'd0;
    end else begin
      lines_full <= {1'b0, bank_st[0] == FULL} + {1'b0, bank_st[1] == FULL};
      if (line_end) begin
        if (frame_line != '1) frame_line <= frame_line + 1'b1;
        if (other_free) begin
          wr_bank <= ~wr_bank;
          drop    <= 1'b0;
        end else begin
          drop     <= 1'b1;
          overflow <= 1'b1;
        end
      end
    end
  end

  assign bus.RAM_WE_O      = ram_we;
  assign bus.RAM_WR_ADDR_O = ram_wr_addr;
  assign bus.RD_GRANT_O    = (rd_state == GRANT);
  assign bus.RD_BANK_O     = rd_bank;
  assign bus.RD_ABORT_O    = rd_abort;
  assign bus.LINES_FULL_O  = lines_full;
  assign bus.OVERFLOW_O    = overflow;
  assign bus.FRAME_LINE_O  = frame_line;

endmodule

// File: tb/tb_line_bank_scheduler.sv
// Directed plus randomized bench for line_bank_scheduler. Expected values come
// from a line-level model: a FIFO of completed banks in write order, the bank
// being read, the bank being written, a drop flag and counters.
module tb_line_bank_scheduler;
  import line_sched_pkg::*;

  localparam int AW = DEF_ADDR_W;
  localparam int LP = DEF_LINE_PIXELS;
  localparam int CW = DEF_LINE_CNT_W;
  localparam int LINE_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  line_bank_scheduler_if #(.ADDR_W(AW), .LINE_CNT_W(CW)) bus ();

  line_bank_scheduler #(.ADDR_W(AW), .LINE_PIXELS(LP), .LINE_CNT_W(CW)) dut (
    .SYS_CLK_I (clk),
    .RESETN_I  (rst_n),
    .bus       (bus)
  );

  // Reference model state
  int m_full[$];   // completed banks, oldest first
  int m_reading;   // bank held by the reader, -1 when none
  int m_wr;        // bank receiving the current line
  bit m_drop;
  bit m_ovf;
  int m_lines;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit bank_free(input int b);
    foreach (m_full[i]) if (m_full[i] == b) return 1'b0;
    return m_reading != b;
  endfunction

  task automatic model_reset();
    m_full.delete();
    m_reading = -1;
    m_wr = 0;
    m_drop = 1'b0;
    m_ovf = 1'b0;
    m_lines = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.WR_VALID_I    = 1'b0;
    bus.WR_ADDR_I     = '0;
    bus.WR_LINE_END_I = 1'b0;
    bus.RD_REQ_I      = 1'b0;
    bus.RD_DONE_I     = 1'b0;
  endtask

  task automatic check_status(input string tag);
    check({tag, "_lines_full"}, 32'(bus.LINES_FULL_O), 32'(m_full.size()));
    check({tag, "_overflow"},   32'(bus.OVERFLOW_O),   32'(m_ovf));
    check({tag, "_frame_line"}, 32'(bus.FRAME_LINE_O), 32'(m_lines));
  endtask

  // One line of n pixels, indices 0..n-1; pixel oor_idx (if >=0) gets an
  // out-of-range index. done_at_end pulses RD_DONE_I with the last pixel.
  task automatic send_line(input int n, input int oor_idx, input bit done_at_end);
    logic [AW-1:0] a;
    bit exp_we;
    int exp_addr;
    for (int i = 0; i < n; i++) begin
      a = (i == oor_idx) ? AW'(LP + (i % 3)) : AW'(i % LP);
      bus.WR_VALID_I    = 1'b1;
      bus.WR_ADDR_I     = a;
      bus.WR_LINE_END_I = (i == n - 1);
      bus.RD_DONE_I     = done_at_end && (i == n - 1);
      exp_we   = !m_drop && (int'(a) < LP);
      exp_addr = (m_wr << AW) | int'(a);
      if (i == n - 1) begin
        if (done_at_end && m_reading >= 0) m_reading = -1;
        if (m_lines < LINE_MAX) m_lines++;
        if (!m_drop) m_full.push_back(m_wr);
        if (bank_free(m_wr ^ 1)) begin
          m_wr ^= 1;
          m_drop = 1'b0;
        end else begin
          m_drop = 1'b1;
          m_ovf = 1'b1;
        end
      end
      tick();
      check("ram_we", 32'(bus.RAM_WE_O), 32'(exp_we));
      if (exp_we) check("ram_wr_addr", 32'(bus.RAM_WR_ADDR_O), exp_addr);
    end
    idle_inputs();
    tick();
    check("ram_we_idle", 32'(bus.RAM_WE_O), 32'd0);
    check_status("line");
  endtask

  // Request a line; leaves the reader busy when a grant is expected.
  task automatic start_read();
    bus.RD_REQ_I = 1'b1;
    if (m_full.size() > 0) begin
      tick();
      check("grant", 32'(bus.RD_GRANT_O), 32'd1);
      check("grant_bank", 32'(bus.RD_BANK_O), 32'(m_full[0]));
      m_reading = m_full.pop_front();
      bus.RD_REQ_I = 1'b0;
      tick();
      check("grant_pulse_end", 32'(bus.RD_GRANT_O), 32'd0);
    end else begin
      repeat (3) begin
        tick();
        check("no_grant", 32'(bus.RD_GRANT_O), 32'd0);
      end
      bus.RD_REQ_I = 1'b0;
    end
  endtask

  task automatic finish_read();
    bus.RD_DONE_I = 1'b1;
    tick();
    bus.RD_DONE_I = 1'b0;
    m_reading = -1;
    tick();
    check("done_lines_full", 32'(bus.LINES_FULL_O), 32'(m_full.size()));
  endtask

  task automatic stray_done();
    bus.RD_DONE_I = 1'b1;
    tick();
    bus.RD_DONE_I = 1'b0;
    tick();
    check("stray_done_lines_full", 32'(bus.LINES_FULL_O), 32'(m_full.size()));
    check("stray_done_grant", 32'(bus.RD_GRANT_O), 32'd0);
  endtask

  task automatic frame_start(input bit with_pixel);
    bit exp_abort;
    exp_abort = (m_reading >= 0);
    bus.V_SYNC_I = 1'b1;
    if (with_pixel) begin
      bus.WR_VALID_I = 1'b1;
      bus.WR_ADDR_I  = AW'(5);
    end
    tick();
    idle_inputs();
    model_reset();
    check("abort", 32'(bus.RD_ABORT_O), 32'(exp_abort));
    check("vsync_we", 32'(bus.RAM_WE_O), 32'd0);
    check_status("vsync");
    tick();
    bus.V_SYNC_I = 1'b0;
    check("abort_pulse_end", 32'(bus.RD_ABORT_O), 32'd0);
    check_status("vsync_settled");
  endtask

  int op;

  initial begin
    bus.V_SYNC_I = 1'b0;
    idle_inputs();
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_we", 32'(bus.RAM_WE_O), 32'd0);
    check("rst_addr", 32'(bus.RAM_WR_ADDR_O), 32'd0);
    check("rst_grant", 32'(bus.RD_GRANT_O), 32'd0);
    check("rst_bank", 32'(bus.RD_BANK_O), 32'd0);
    check("rst_abort", 32'(bus.RD_ABORT_O), 32'd0);
    check_status("rst");
    rst_n = 1'b1;
    tick();

    // Full line into bank 0, then read it; next line lands in bank 1
    send_line(LP, -1, 1'b0);
    start_read();
    finish_read();
    send_line(LP, -1, 1'b0);

    // Three lines with no reads: third is dropped; then retry after a read
    frame_start(1'b0);
    send_line(LP, -1, 1'b0);
    send_line(LP, -1, 1'b0);
    send_line(LP, -1, 1'b0);
    start_read();
    finish_read();
    send_line(8, -1, 1'b0);
    send_line(8, -1, 1'b0);

    // Line end in the same cycle as the reader freeing the other bank
    frame_start(1'b0);
    send_line(6, -1, 1'b0);
    start_read();
    send_line(10, -1, 1'b1);

    // Frame start while the reader is busy, with a pixel on the edge cycle
    send_line(5, -1, 1'b0);
    start_read();
    frame_start(1'b1);
    send_line(5, -1, 1'b0);

    // Out-of-range pixel index, including on the closing pixel
    frame_start(1'b0);
    send_line(4, 3, 1'b0);
    send_line(6, 2, 1'b0);

    // Empty request and a stray done outside BUSY
    frame_start(1'b0);
    start_read();
    stray_done();

    // Line counter saturation
    frame_start(1'b0);
    for (int i = 0; i < LINE_MAX + 4; i++) send_line(1, -1, 1'b0);

    // Randomized mix of lines, reads and frame starts
    frame_start(1'b0);
    for (int it = 0; it < 400; it++) begin
      op = $urandom_range(0, 11);
      if (op <= 5) begin
        send_line($urandom_range(1, 12),
                  ($urandom_range(0, 3) == 0) ? $urandom_range(0, 11) : -1,
                  (m_reading >= 0) && ($urandom_range(0, 1) == 1));
      end else if (op <= 8) begin
        if (m_reading >= 0) finish_read();
        else start_read();
      end else if (op == 9) begin
        if (m_reading < 0) stray_done();
        else finish_read();
      end else if (op == 10 && $urandom_range(0, 3) == 0) begin
        frame_start($urandom_range(0, 1) == 1);
      end else begin
        send_line(1, -1, 1'b0);
      end
    end

    // Asynchronous reset in the middle of a read
    frame_start(1'b0);
    send_line(7, -1, 1'b0);
    start_read();
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_we", 32'(bus.RAM_WE_O), 32'd0);
    check("arst_addr", 32'(bus.RAM_WR_ADDR_O), 32'd0);
    check("arst_grant", 32'(bus.RD_GRANT_O), 32'd0);
    check("arst_bank", 32'(bus.RD_BANK_O), 32'd0);
    check("arst_abort", 32'(bus.RD_ABORT_O), 32'd0);
    check_status("arst");
    tick();
    rst_n = 1'b1;
    tick();
    check("arst_no_abort", 32'(bus.RD_ABORT_O), 32'd0);
    send_line(3, -1, 1'b0);
    start_read();
    finish_read();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
